// File: rtl/datapath_p_pkg.sv
// datapath_p_pkg: shared ALU opcodes, Xbus/debug select codes, xdst bit indices,
// flag bit positions and memory FSM encoding for the parametrised datapath.
package datapath_p_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADC  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SBB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOT  = 4'd7;
    localparam logic [3:0] ALU_MOVA = 4'd8;
    localparam logic [3:0] ALU_MOVB = 4'd9;
    localparam logic [3:0] ALU_INC  = 4'd10;
    localparam logic [3:0] ALU_DEC  = 4'd11;
    localparam logic [3:0] ALU_SHL  = 4'd12;
    localparam logic [3:0] ALU_SHR  = 4'd13;

    localparam logic [3:0] XS_PC   = 4'd0;
    localparam logic [3:0] XS_G0   = 4'd1;
    localparam logic [3:0] XS_MDR  = 4'd9;
    localparam logic [3:0] XS_R    = 4'd10;
    localparam logic [3:0] XS_FLG  = 4'd11;
    localparam logic [3:0] XS_ONES = 4'd12;

    localparam logic [3:0] DB_T    = 4'd9;
    localparam logic [3:0] DB_XBUS = 4'd12;
    localparam logic [3:0] DB_MDR  = 4'd13;
    localparam logic [3:0] DB_BUSY = 4'd14;

    localparam int XD_PC  = 0;
    localparam int XD_G0  = 1;
    localparam int XD_MA  = 9;
    localparam int XD_WD  = 10;
    localparam int XD_I   = 11;
    localparam int XD_T   = 12;
    localparam int XD_R   = 13;
    localparam int XD_FLG = 14;

    localparam int FLG_S  = 3;
    localparam int FLG_Z  = 2;
    localparam int FLG_CY = 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;
endpackage

// File: rtl/datapath_p_alu.sv
// alu_p: combinational ALU; the extra result bit carries the carry (adds/shl)
// or the borrow (subtracts/dec) out of bit WIDTH-1.
module alu_p
    import datapath_p_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cy
);
    logic [WIDTH:0] ax, bx, cx, one, s;

    assign ax  = {1'b0, a};
    assign bx  = {1'b0, b};
    assign cx  = (WIDTH+1)'(cin);
    assign one = (WIDTH+1)'(1);

    always_comb begin
        case (op)
            ALU_ADD:  s = ax + bx;
            ALU_ADC:  s = ax + bx + cx;
            ALU_SUB:  s = ax - bx;
            ALU_SBB:  s = ax - bx - cx;
            ALU_AND:  s = ax & bx;
            ALU_OR:   s = ax | bx;
            ALU_XOR:  s = ax ^ bx;
            ALU_NOT:  s = {1'b0, ~a};
            ALU_MOVA: s = ax;
            ALU_MOVB: s = bx;
            ALU_INC:  s = ax + one;
            ALU_DEC:  s = ax - one;
            ALU_SHL:  s = {a, 1'b0};
            ALU_SHR:  s = ax >> 1;
            default:  s = '0;
        endcase
    end

    assign y  = s[WIDTH-1:0];
    assign cy = s[WIDTH];
endmodule

// File: rtl/datapath_p.sv
// datapath_p: parametrised CDEC datapath with PC auto-increment, MDR and a
// req/ack memory handshake FSM tolerant of wait states.
module datapath_p
    import datapath_p_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NGPR  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       xsrc,
    input  logic [14:0]      xdst,
    input  logic [3:0]       aluop,
    input  logic             pc_inc,
    input  logic             mem_start,
    input  logic             mem_write,
    output logic             busy,
    output logic [WIDTH-1:0] I,
    output logic [2:0]       SZCy,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);
    logic [WIDTH-1:0] pc_q, pc_d, ma_q, ma_d, wd_q, wd_d, i_q, i_d;
    logic [WIDTH-1:0] t_q, t_d, r_q, r_d, flg_q, flg_d, mdr_q, mdr_d;
    // Eight slots always exist; slots at or above NGPR never load and stay zero.
    logic [WIDTH-1:0] g_q [8];
    logic [WIDTH-1:0] g_d [8];
    logic [0:0]       st_q, st_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] src [16];
    logic [WIDTH-1:0] xbus, alu_y, flg_new;
    logic             alu_cy;

    alu_p #(.WIDTH(WIDTH)) u_alu (
        .op  (aluop),
        .a   (xbus),
        .b   (t_q),
        .cin (flg_q[FLG_CY]),
        .y   (alu_y),
        .cy  (alu_cy)
    );

    always_comb begin
        for (int k = 0; k < 16; k++) src[k] = '0;
        src[XS_PC] = pc_q;
        for (int n = 0; n < 8; n++) src[int'(XS_G0) + n] = g_q[n];
        src[XS_MDR]  = mdr_q;
        src[XS_R]    = r_q;
        src[XS_FLG]  = flg_q;
        src[XS_ONES] = '1;
    end

    assign xbus = src[xsrc];
    assign busy = st_q == ST_REQ;

    always_comb begin
        dbg_data = dbg_addr == DB_T    ? t_q   :
                   dbg_addr == DB_XBUS ? xbus  :
                   dbg_addr == DB_MDR  ? mdr_q :
                   dbg_addr == DB_BUSY ? WIDTH'(busy) : src[dbg_addr];
    end

    always_comb begin
        flg_new         = '0;
        flg_new[FLG_S]  = alu_y[WIDTH-1];
        flg_new[FLG_Z]  = alu_y == '0;
        flg_new[FLG_CY] = alu_cy;
    end

    always_comb begin
        pc_d  = xdst[XD_PC] ? xbus : pc_inc ? pc_q + WIDTH'(1) : pc_q;
        for (int n = 0; n < 8; n++) g_d[n] = (n < NGPR && xdst[XD_G0 + n]) ? xbus : g_q[n];
        ma_d  = (xdst[XD_MA] && !busy) ? xbus : ma_q;
        wd_d  = (xdst[XD_WD] && !busy) ? xbus : wd_q;
        i_d   = xdst[XD_I] ? xbus : i_q;
        t_d   = xdst[XD_T] ? xbus : t_q;
        r_d   = xdst[XD_R] ? alu_y : r_q;
        flg_d = xdst[XD_FLG] ? flg_new : flg_q;
        st_d  = st_q == ST_IDLE ? (mem_start ? ST_REQ : ST_IDLE) : (mem_ack ? ST_IDLE : ST_REQ);
        we_d  = (st_q == ST_IDLE && mem_start) ? mem_write : we_q;
        mdr_d = (st_q == ST_REQ && mem_ack && !we_q) ? mem_rdata : mdr_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            for (int n = 0; n < 8; n++) g_q[n] <= '0;
            ma_q  <= '0;
            wd_q  <= '0;
            i_q   <= '0;
            t_q   <= '0;
            r_q   <= '0;
            flg_q <= '0;
            mdr_q <= '0;
            st_q  <= ST_IDLE;
            we_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            for (int n = 0; n < 8; n++) g_q[n] <= g_d[n];
            ma_q  <= ma_d;
            wd_q  <= wd_d;
            i_q   <= i_d;
            t_q   <= t_d;
            r_q   <= r_d;
            flg_q <= flg_d;
            mdr_q <= mdr_d;
            st_q  <= st_d;
            we_q  <= we_d;
        end
    end

    assign I         = i_q;
    assign SZCy      = flg_q[FLG_S:FLG_CY];
    assign mem_req   = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = ma_q;
    assign mem_wdata = wd_q;
endmodule

// File: tb/tb_datapath_p.sv
// tb_datapath_p: random and directed stimulus against a transaction-level model
// of the 8-bit/3-GPR datapath, plus directed checks of a 16-bit/8-GPR instance.
module tb_datapath_p;
    import datapath_p_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [3:0]  xsrc, aluop, dbg_addr;
    logic [14:0] xdst;
    logic        pc_inc, mem_start, mem_write, mem_ack;
    logic [7:0]  mem_rdata;
    logic        busy, mem_req, mem_we;
    logic [7:0]  I, mem_addr, mem_wdata, dbg_data;
    logic [2:0]  SZCy;

    logic [3:0]  w_xsrc, w_aluop, w_dbg_addr;
    logic [14:0] w_xdst;
    logic        w_busy, w_mem_req, w_mem_we;
    logic [15:0] w_I, w_mem_addr, w_mem_wdata, w_dbg_data;
    logic [2:0]  w_SZCy;

    datapath_p #(.WIDTH(8), .NGPR(3)) u_dut (
        .clock(clock), .reset(reset), .xsrc(xsrc), .xdst(xdst), .aluop(aluop),
        .pc_inc(pc_inc), .mem_start(mem_start), .mem_write(mem_write), .busy(busy),
        .I(I), .SZCy(SZCy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    datapath_p #(.WIDTH(16), .NGPR(8)) u_wide (
        .clock(clock), .reset(reset), .xsrc(w_xsrc), .xdst(w_xdst), .aluop(w_aluop),
        .pc_inc(1'b0), .mem_start(1'b0), .mem_write(1'b0), .busy(w_busy),
        .I(w_I), .SZCy(w_SZCy), .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
        .mem_wdata(w_mem_wdata), .mem_rdata(16'h0), .mem_ack(1'b0),
        .dbg_addr(w_dbg_addr), .dbg_data(w_dbg_data)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Architectural state of the 8-bit instance.
    int unsigned m_pc, m_ma, m_wd, m_i, m_t, m_r, m_flg, m_mdr;
    int unsigned m_g [3];
    bit          m_busy, m_we;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned xsel(input int code);
        case (code)
            0:       return m_pc;
            1, 2, 3: return m_g[code-1];
            9:       return m_mdr;
            10:      return m_r;
            11:      return m_flg;
            12:      return 32'hFF;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned dsel(input int code);
        case (code)
            9:       return m_t;
            12:      return xsel(int'(xsrc));
            13:      return m_mdr;
            14:      return int'(m_busy);
            default: return xsel(code);
        endcase
    endfunction

    function automatic void alu_ref(input int op, input longint a, input longint b, input longint cin,
                                    input longint mask, output longint y, output bit c);
        longint f;
        case (op)
            0:  f = a + b;
            1:  f = a + b + cin;
            2:  f = a - b;
            3:  f = a - b - cin;
            4:  f = a & b;
            5:  f = a | b;
            6:  f = a ^ b;
            7:  f = ~a & mask;
            8:  f = a;
            9:  f = b;
            10: f = a + 1;
            11: f = a - 1;
            12: f = a * 2;
            13: f = a / 2;
            default: f = 0;
        endcase
        y = f & mask;
        c = (f < 0) || (f > mask);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ma = 0; m_wd = 0; m_i = 0; m_t = 0; m_r = 0; m_flg = 0; m_mdr = 0;
        foreach (m_g[k]) m_g[k] = 0;
        m_busy = 0; m_we = 0;
    endtask

    task automatic idle();
        xdst = '0; pc_inc = 0; mem_start = 0; mem_ack = 0;
    endtask

    task automatic peek(input logic [3:0] a, input int unsigned exp, input string tag);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // One clock: predict, advance, then compare every visible output.
    task automatic step();
        int unsigned xb, n_pc, n_ma, n_wd, n_i, n_t, n_r, n_flg, n_mdr;
        int unsigned n_g [3];
        bit n_busy, n_we, c;
        longint y;
        xb = xsel(int'(xsrc));
        alu_ref(int'(aluop), xb, m_t, (m_flg >> 1) & 1, 64'hFF, y, c);
        n_pc  = xdst[0] ? xb : pc_inc ? (m_pc + 1) % 256 : m_pc;
        foreach (n_g[k]) n_g[k] = xdst[1+k] ? xb : m_g[k];
        n_ma  = (xdst[9] && !m_busy) ? xb : m_ma;
        n_wd  = (xdst[10] && !m_busy) ? xb : m_wd;
        n_i   = xdst[11] ? xb : m_i;
        n_t   = xdst[12] ? xb : m_t;
        n_r   = xdst[13] ? int'(y) : m_r;
        n_flg = xdst[14] ? (((int'(y) >> 7) & 1) << 3) | (int'(y == 0) << 2) | (int'(c) << 1) : m_flg;
        n_busy = m_busy ? !mem_ack : mem_start;
        n_we   = (!m_busy && mem_start) ? mem_write : m_we;
        n_mdr  = (m_busy && mem_ack && !m_we) ? mem_rdata : m_mdr;
        @(posedge clock);
        #1;
        m_pc = n_pc; m_g = n_g; m_ma = n_ma; m_wd = n_wd; m_i = n_i; m_t = n_t;
        m_r = n_r; m_flg = n_flg; m_busy = n_busy; m_we = n_we; m_mdr = n_mdr;
        chk("busy", busy, m_busy);
        chk("mem_req", mem_req, m_busy);
        chk("mem_we", mem_we, m_busy & m_we);
        chk("mem_addr", mem_addr, m_ma);
        chk("mem_wdata", mem_wdata, m_wd);
        chk("I", I, m_i);
        chk("SZCy", SZCy, (m_flg >> 1) & 7);
        dbg_addr = 4'($urandom_range(0, 15));
        #1;
        chk($sformatf("dbg%0d", dbg_addr), dbg_data, dsel(int'(dbg_addr)));
    endtask

    task automatic load_pc(input int v);
        idle();
        xsrc = 4'd15; xdst = 15'h1;
        step();
        xdst = '0; pc_inc = 1;
        repeat (v) step();
        pc_inc = 0;
    endtask

    task automatic copy(input int dbit, input logic [3:0] s);
        xsrc = s; xdst = 15'(1) << dbit;
        step();
        xdst = '0;
    endtask

    task automatic wtick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int req_cnt, busy_cnt;
        reset = 0; idle(); xsrc = 0; aluop = 0; dbg_addr = 0; mem_write = 0; mem_rdata = 0;
        w_xsrc = 0; w_xdst = 0; w_aluop = 0; w_dbg_addr = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #2 reset = 1;
        for (int a = 0; a < 16; a++) peek(4'(a), 0, "reset_dbg");

        xsrc = XS_ONES; xdst = 15'h1;
        step();
        peek(4'd0, 32'hFF, "pc_load_ff");
        xdst = '0; pc_inc = 1;
        step();
        peek(4'd0, 32'h00, "pc_wrap");
        load_pc(16);
        copy(2, XS_PC);
        copy(0, XS_ONES);
        xsrc = 4'd2; xdst = 15'h1; pc_inc = 1;
        step();
        peek(4'd0, 32'h10, "pc_priority");
        idle();

        load_pc(240);
        copy(1, XS_PC);
        load_pc(32);
        copy(12, XS_PC);
        xsrc = 4'd1; aluop = ALU_ADD; xdst = 15'h6000;
        step();
        chk("add_szcy", SZCy, 3'b001);
        peek(4'd10, 32'h10, "add_r");
        idle();

        load_pc(64);
        copy(9, XS_PC);
        mem_write = 0; mem_start = 1;
        step();
        req_cnt = int'(mem_req); busy_cnt = int'(busy);
        repeat (3) begin
            mem_start = 1; xsrc = XS_ONES; xdst = 15'h0200;
            step();
            req_cnt += int'(mem_req); busy_cnt += int'(busy);
            chk("rd_addr_hold", mem_addr, 8'h40);
        end
        idle(); mem_ack = 1; mem_rdata = 8'hA5;
        step();
        req_cnt += int'(mem_req); busy_cnt += int'(busy);
        idle();
        chk("rd_req_cycles", req_cnt, 4);
        chk("rd_busy_cycles", busy_cnt, 4);
        peek(DB_MDR, 32'hA5, "rd_mdr");
        step();
        chk("rd_start_ignored", busy, 0);

        load_pc(60);
        copy(10, XS_PC);
        load_pc(128);
        copy(9, XS_PC);
        mem_write = 1; mem_start = 1;
        step();
        mem_start = 0;
        repeat (2) begin
            step();
            chk("wr_we", mem_we, 1);
            chk("wr_addr", mem_addr, 8'h80);
            chk("wr_wdata", mem_wdata, 8'h3C);
        end
        mem_ack = 1; mem_rdata = 8'h11;
        step();
        idle();
        chk("wr_done", mem_we, 0);
        peek(DB_MDR, 32'hA5, "wr_mdr_kept");

        xsrc = XS_ONES; xdst = 15'h01F0;
        step();
        peek(4'd5, 0, "ngpr_g4");
        peek(4'd8, 0, "ngpr_g7");
        xsrc = 4'd5; xdst = 15'h1000;
        step();
        peek(DB_T, 0, "ngpr_t_from_g4");
        idle();

        for (int n = 0; n < 600; n++) begin
            xsrc = 4'($urandom_range(0, 15));
            xdst = 15'($urandom);
            aluop = 4'($urandom_range(0, 15));
            pc_inc = 1'($urandom);
            mem_start = $urandom_range(0, 3) == 0;
            mem_write = 1'($urandom);
            mem_ack = $urandom_range(0, 2) == 0;
            mem_rdata = 8'($urandom);
            step();
        end

        idle();
        while (m_busy) begin
            mem_ack = 1;
            step();
        end
        idle(); mem_write = 0; mem_start = 1;
        step();
        idle(); mem_ack = 1; mem_rdata = 8'h77; xsrc = XS_PC;
        #1 reset = 0;
        model_reset();
        for (int a = 0; a < 16; a++) peek(4'(a), 0, "midrun_reset_dbg");
        chk("midrun_reset_req", mem_req, 0);
        chk("midrun_reset_busy", busy, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1; mem_ack = 0;
        peek(DB_MDR, 0, "reset_beats_ack");

        w_xsrc = XS_ONES; w_xdst = 15'h0100;
        wtick();
        w_xdst = '0; w_dbg_addr = 4'd8;
        #1 chk("w_g7", w_dbg_data, 16'hFFFF);
        w_xsrc = 4'd8; w_xdst = 15'h1000;
        wtick();
        w_dbg_addr = DB_T;
        #1 chk("w_t_from_g7", w_dbg_data, 16'hFFFF);
        w_xsrc = 4'd8; w_aluop = ALU_INC; w_xdst = 15'h6000;
        wtick();
        w_xdst = '0;
        chk("w_inc_szcy", w_SZCy, 3'b011);
        w_dbg_addr = 4'd10;
        #1 chk("w_inc_r", w_dbg_data, 16'h0000);
        w_xsrc = XS_ONES; w_aluop = ALU_ADD; w_xdst = 15'h6000;
        wtick();
        w_xdst = '0;
        chk("w_add_szcy", w_SZCy, 3'b101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
